// File: rtl/rrp_mac.sv
`default_nettype none
// ============================================================================
// rrp_mac -- pipelined signed-digit multiply-accumulate, carry-free datapath.
// Revision: 1.0
// ============================================================================
module rrp_mac #(
    parameter  int RADIX = 4,
    parameter  int WIDTH = 8,
    parameter  int GUARD = 4,
    parameter  int CNT_W = 8,
    localparam int D     = $clog2(RADIX) + 1,
    localparam int ACC_N = 2*WIDTH + 1 + GUARD
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 hold,
    input  logic                 in_valid,
    input  logic                 acc_clear,
    input  logic                 mode,
    input  logic [D*WIDTH-1:0]   x_in,
    input  logic [D*WIDTH-1:0]   y_in,
    output logic                 out_valid,
    output logic [D*ACC_N-1:0]   acc_out,
    output logic [CNT_W-1:0]     acc_count
);

    localparam int LR = $clog2(RADIX);
    localparam int SW = D + 2;
    localparam int PW = 2 * D;

    typedef logic signed [SW-1:0] sum_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic [D*ACC_N-1:0]   vec_t;

    localparam sum_t C_R   = sum_t'(RADIX);
    localparam sum_t C_RM1 = sum_t'(RADIX - 1);
    localparam sum_t C_ONE = sum_t'(1);

    // Two-step carry-free add. The transfer polarity out of digit i-1 is known
    // from the sign of its raw sum, so digit i picks an interim range that can
    // absorb it. The top digit keeps its raw sum so no transfer is ever dropped.
    function automatic vec_t sd_add(input vec_t a, input vec_t b);
        sum_t s [ACC_N];
        sum_t w [ACC_N];
        sum_t c [ACC_N];
        logic ng [ACC_N];
        sum_t z;
        vec_t r;
        r     = '0;
        c[0]  = '0;
        ng[0] = 1'b0;
        for (int i = 0; i < ACC_N; i++) begin
            s[i] = sum_t'($signed(a[i*D +: D])) + sum_t'($signed(b[i*D +: D]));
        end
        for (int i = 1; i < ACC_N; i++) begin
            ng[i] = s[i-1][SW-1];
        end
        for (int i = 0; i < ACC_N - 1; i++) begin
            w[i]   = s[i];
            c[i+1] = '0;
            if (s[i] >= (ng[i] ? C_R : C_RM1)) begin
                w[i]   = s[i] - C_R;
                c[i+1] = C_ONE;
            end else if (s[i] <= (ng[i] ? -C_RM1 : -C_R)) begin
                w[i]   = s[i] + C_R;
                c[i+1] = -C_ONE;
            end
        end
        w[ACC_N-1] = s[ACC_N-1];
        for (int i = 0; i < ACC_N; i++) begin
            z = w[i] + c[i];
            if (z > C_RM1) begin
                z = C_RM1;
            end else if (z < -C_RM1) begin
                z = -C_RM1;
            end
            r[i*D +: D] = D'(z);
        end
        return r;
    endfunction

    // Each digit product splits into a legal low digit [0,R-1] and high digit.
    function automatic vec_t pp_row(input logic [D*WIDTH-1:0] x, input logic [D-1:0] yd,
                                    input int j, input logic hi);
        prod_t p;
        vec_t  r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p = prod_t'($signed(x[i*D +: D])) * prod_t'($signed(yd));
            if (hi) begin
                r[(i+j+1)*D +: D] = D'(p >>> LR);
            end else begin
                r[(i+j)*D +: D] = {1'b0, p[LR-1:0]};
            end
        end
        return r;
    endfunction

    logic [D*WIDTH-1:0] x_q [WIDTH];
    logic [D*WIDTH-1:0] y_q [WIDTH];
    logic               v_q [WIDTH+3];
    logic               clr_q [WIDTH+2];
    logic               mode_q [WIDTH+2];
    vec_t               sl_q [1:WIDTH];
    vec_t               sh_q [1:WIDTH];
    vec_t               sl_d [1:WIDTH];
    vec_t               sh_d [1:WIDTH];
    vec_t               prod_q, prod_d;
    vec_t               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q;

    always_comb begin
        sl_d[1] = pp_row(x_q[0], y_q[0][0 +: D], 0, 1'b0);
        sh_d[1] = pp_row(x_q[0], y_q[0][0 +: D], 0, 1'b1);
        for (int k = 2; k <= WIDTH; k++) begin
            sl_d[k] = sd_add(sl_q[k-1], pp_row(x_q[k-1], y_q[k-1][(k-1)*D +: D], k-1, 1'b0));
            sh_d[k] = sd_add(sh_q[k-1], pp_row(x_q[k-1], y_q[k-1][(k-1)*D +: D], k-1, 1'b1));
        end
        prod_d = sd_add(sl_q[WIDTH], sh_q[WIDTH]);
        acc_d  = sd_add(acc_q, prod_q);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int k = 0; k < WIDTH; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
            for (int k = 0; k < WIDTH + 3; k++) begin
                v_q[k] <= 1'b0;
            end
            for (int k = 0; k < WIDTH + 2; k++) begin
                clr_q[k]  <= 1'b0;
                mode_q[k] <= 1'b0;
            end
            for (int k = 1; k <= WIDTH; k++) begin
                sl_q[k] <= '0;
                sh_q[k] <= '0;
            end
            prod_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            acc_count <= '0;
        end else if (!hold) begin
            x_q[0]    <= x_in;
            y_q[0]    <= y_in;
            v_q[0]    <= in_valid;
            clr_q[0]  <= acc_clear;
            mode_q[0] <= mode;
            for (int k = 1; k < WIDTH; k++) begin
                x_q[k] <= x_q[k-1];
                y_q[k] <= y_q[k-1];
            end
            for (int k = 1; k < WIDTH + 2; k++) begin
                clr_q[k]  <= clr_q[k-1];
                mode_q[k] <= mode_q[k-1];
            end
            for (int k = 1; k < WIDTH + 3; k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int k = 1; k <= WIDTH; k++) begin
                sl_q[k] <= sl_d[k];
                sh_q[k] <= sh_d[k];
            end
            prod_q <= prod_d;
            if (v_q[WIDTH+1]) begin
                if (!mode_q[WIDTH+1] || clr_q[WIDTH+1]) begin
                    acc_q <= prod_q;
                    cnt_q <= CNT_W'(1);
                end else begin
                    acc_q <= acc_d;
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
            // Output register holds its value across bubbles.
            out_valid <= v_q[WIDTH+2];
            if (v_q[WIDTH+2]) begin
                acc_out   <= acc_q;
                acc_count <= cnt_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rrp_mac.sv
`default_nettype none
// ============================================================================
// tb_rrp_mac -- directed and random checks of rrp_mac against a value model.
// Revision: 1.0
// ============================================================================
module tb_rrp_mac;

    localparam int RADIX = 4;
    localparam int WIDTH = 4;
    localparam int GUARD = 4;
    localparam int CNT_W = 8;
    localparam int D     = 3;
    localparam int ACC_N = 13;
    localparam int LAT   = 8;
    localparam longint BOUND = 64'd16777216;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic                 hold = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 acc_clear = 1'b0;
    logic                 mode = 1'b0;
    logic [D*WIDTH-1:0]   x_in = '0;
    logic [D*WIDTH-1:0]   y_in = '0;
    logic                 out_valid;
    logic [D*ACC_N-1:0]   acc_out;
    logic [CNT_W-1:0]     acc_count;

    int     n_cmp = 0;
    int     n_fail = 0;
    string  phase = "init";

    logic   ml_v   [LAT];
    longint ml_val [LAT];
    int     ml_cnt [LAT];
    longint macc;
    int     mcnt;
    logic   exp_ov;
    longint exp_acc;
    int     exp_cnt;

    rrp_mac #(.RADIX(RADIX), .WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .hold      (hold),
        .in_valid  (in_valid),
        .acc_clear (acc_clear),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .acc_out   (acc_out),
        .acc_count (acc_count)
    );

    always #5 clock = ~clock;

    function automatic logic [D*WIDTH-1:0] enc(input longint v);
        logic [D*WIDTH-1:0] r;
        longint t, d;
        r = '0;
        t = v;
        for (int i = 0; i < WIDTH; i++) begin
            d = t % 4;
            r[i*D +: D] = 3'(d);
            t = (t - d) / 4;
        end
        return r;
    endfunction

    function automatic longint dec(input logic [D*ACC_N-1:0] a);
        longint s, w;
        s = 0;
        w = 1;
        for (int i = 0; i < ACC_N; i++) begin
            s = s + longint'($signed(a[i*D +: D])) * w;
            w = w * 4;
        end
        return s;
    endfunction

    function automatic logic legal(input logic [D*ACC_N-1:0] a);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < ACC_N; i++) begin
            if (a[i*D +: D] == 3'b100) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the value model by one edge, compare outputs.
    task automatic step(input logic rn, input logic hd, input logic v, input logic clr,
                        input logic md, input longint xv, input longint yv);
        resetn    = rn;
        hold      = hd;
        in_valid  = v;
        acc_clear = clr;
        mode      = md;
        x_in      = enc(xv);
        y_in      = enc(yv);
        @(posedge clock);
        #1;
        if (!rn) begin
            for (int k = 0; k < LAT; k++) begin
                ml_v[k] = 1'b0; ml_val[k] = 0; ml_cnt[k] = 0;
            end
            macc = 0; mcnt = 0; exp_ov = 1'b0; exp_acc = 0; exp_cnt = 0;
        end else if (!hd) begin
            if (v) begin
                if (!md || clr) begin
                    macc = xv * yv; mcnt = 1;
                end else begin
                    macc = macc + xv * yv;
                    if (mcnt < 255) mcnt++;
                end
            end
            for (int k = LAT - 1; k > 0; k--) begin
                ml_v[k] = ml_v[k-1]; ml_val[k] = ml_val[k-1]; ml_cnt[k] = ml_cnt[k-1];
            end
            ml_v[0] = v; ml_val[0] = macc; ml_cnt[0] = mcnt;
            exp_ov = ml_v[LAT-1];
            if (exp_ov) begin
                exp_acc = ml_val[LAT-1];
                exp_cnt = ml_cnt[LAT-1];
            end
        end
        chk({phase, ".ov"}, out_valid, exp_ov);
        chk({phase, ".acc"}, dec(acc_out), exp_acc);
        chk({phase, ".cnt"}, acc_count, exp_cnt);
        chk({phase, ".legal"}, legal(acc_out), 1);
    endtask

    // Three-term stream; with_hold freezes three cycles after the second term.
    task automatic run_stream(input logic with_hold);
        longint st_val [3];
        int     st_at  [3];
        int     n;
        st_val = '{35, 23, 27};
        if (with_hold) st_at = '{10, 11, 12};
        else           st_at = '{7, 8, 9};
        n = 0;
        for (int s = 0; s < 18; s++) begin
            if (s == 0)                          step(1, 0, 1, 1, 1, 5, 7);
            else if (s == 1)                     step(1, 0, 1, 0, 1, -3, 4);
            else if (with_hold && s >= 2 && s <= 4) step(1, 1, 1, 1, 0, 7, -5);
            else if ((with_hold && s == 5) || (!with_hold && s == 2))
                                                 step(1, 0, 1, 0, 1, 2, 2);
            else                                 step(1, 0, 0, 0, 0, 0, 0);
            if (out_valid) begin
                if (n < 3) begin
                    chk({phase, ".at"}, s, st_at[n]);
                    chk({phase, ".val"}, dec(acc_out), st_val[n]);
                    chk({phase, ".n"}, acc_count, n + 1);
                end
                n++;
            end
        end
        chk({phase, ".pulses"}, n, 3);
    endtask

    initial begin
        logic   v, hd, md, clr;
        longint xv, yv, p, na;
        int     pulses;

        phase = "reset";
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 5, 5);
        chk("reset.ov0", out_valid, 0);
        chk("reset.acc0", dec(acc_out), 0);
        chk("reset.cnt0", acc_count, 0);

        phase = "single";
        for (int k = 0; k < 12; k++) begin
            if (k == 0) step(1, 0, 1, 0, 0, 3, -2);
            else        step(1, 0, 0, 0, 0, 0, 0);
            chk("single.ov_at", out_valid, (k == 7));
            if (k == 7) begin
                chk("single.val", dec(acc_out), -6);
                chk("single.cnt", acc_count, 1);
            end
        end

        phase = "stream";
        run_stream(1'b0);
        phase = "holdstream";
        run_stream(1'b1);

        phase = "maxacc";
        pulses = 0;
        for (int i = 0; i < 268; i++) begin
            if (i < 256) step(1, 0, 1, (i == 0), 1, 255, 255);
            else         step(1, 0, 0, 0, 0, 0, 0);
            if (out_valid) pulses++;
        end
        chk("maxacc.pulses", pulses, 256);
        chk("maxacc.val", dec(acc_out), 64'd16646400);
        chk("maxacc.cnt", acc_count, 255);
        chk("maxacc.legal", legal(acc_out), 1);

        phase = "flush";
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, i + 1, 3);
        step(0, 1, 1, 1, 0, 9, 9);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (out_valid) pulses++;
        end
        chk("flush.pulses", pulses, 0);
        chk("flush.acc0", dec(acc_out), 0);
        chk("flush.cnt0", acc_count, 0);
        for (int k = 0; k < 10; k++) begin
            if (k == 0) step(1, 0, 1, 0, 1, 6, 3);
            else        step(1, 0, 0, 0, 0, 0, 0);
            chk("flush.ov_at", out_valid, (k == 7));
            if (k == 7) begin
                chk("flush.val", dec(acc_out), 18);
                chk("flush.cnt", acc_count, 1);
            end
        end

        phase = "random";
        for (int i = 0; i < 1000; i++) begin
            v   = ($urandom_range(0, 9) < 8);
            hd  = ($urandom_range(0, 9) == 0);
            md  = $urandom_range(0, 1) == 1;
            clr = ($urandom_range(0, 7) == 0);
            xv = 0; yv = 0;
            for (int j = 3; j >= 0; j--) begin
                xv = xv * 4 + longint'(int'($urandom_range(0, 6)) - 3);
                yv = yv * 4 + longint'(int'($urandom_range(0, 6)) - 3);
            end
            p  = xv * yv;
            na = macc + p;
            if (na < 0) na = -na;
            if (v && !hd && md && !clr && na > BOUND) clr = 1'b1;
            step(1, hd, v, clr, md, xv, yv);
        end
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
